conv_controller: RTL and testbench

Sequencing FSM for the convolution datapath. It steps the IF-map generator and filter generator through every window and filter. It drives RAM/SRAM read enables and the operand/accumulator register loads around the multiplier/adder pair, and hands each finished partial sum to the output writer through a valid/ready handshake. One instance sits beside the datapath and is its only source of control strobes.

---
 rtl/conv_ctrl_pkg.sv | 22 ++
 rtl/conv_controller_if.sv | 23 ++
 rtl/conv_ctrl_pipe.sv | 36 +++
 rtl/conv_controller.sv | 201 ++++++++++++++++++++
 tb/tb_conv_controller.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_ctrl_pkg.sv
// conv_ctrl_pkg: shared types and constants for the convolution controller.
// Holds the FSM state enum, operand pipeline depth and perf counter width.
package conv_ctrl_pkg;

    // Read -> operand load -> accumulate latency of the datapath.
    localparam int PIPE_DEPTH = 2;

    // Width of the optional performance counters.
    localparam int PERF_W = 16;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INIT      = 3'd1,
        S_MAC       = 3'd2,
        S_DRAIN     = 3'd3,
        S_WRITE     = 3'd4,
        S_NEXT_FILT = 3'd5,
        S_NEXT_WIN  = 3'd6,
        S_DONE      = 3'd7
    } state_e;

endpackage

// File: rtl/conv_controller_if.sv
// conv_controller_if: partial-sum valid/ready channel to the output writer.
// Ports: psum_valid, psum_waddr (master out), psum_ready (master in).
interface conv_controller_if #(
    parameter int ADDR_WIDTH = 4
);

    logic                  psum_valid;
    logic                  psum_ready;
    logic [ADDR_WIDTH-1:0] psum_waddr;

    modport master (
        output psum_valid,
        output psum_waddr,
        input  psum_ready
    );

    modport slave (
        input  psum_valid,
        input  psum_waddr,
        output psum_ready
    );

endinterface

// File: rtl/conv_ctrl_pipe.sv
// conv_ctrl_pipe: valid shift register following each memory read.
// Ports: clk, rst (async low), rd_vld_i in; op_ld_o, acc_ld_o out.
module conv_ctrl_pipe
    import conv_ctrl_pkg::*;
#(
    parameter int DEPTH = PIPE_DEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic rd_vld_i,
    output logic op_ld_o,
    output logic acc_ld_o
);

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;

    // Stage 0 is "data at operand registers", last stage is "add done".
    if (DEPTH > 1) begin : g_multi
        assign vld_d = {vld_q[DEPTH-2:0], rd_vld_i};
    end else begin : g_single
        assign vld_d = rd_vld_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    assign op_ld_o  = vld_q[0];
    assign acc_ld_o = vld_q[DEPTH-1];

endmodule

// File: rtl/conv_controller.sv
// conv_controller: sequencing FSM for the convolution datapath.
// Ports: clk, rst (async low), start, generator flags in; generator,
// memory, operand/accumulator strobes, busy, done out; psum channel via
// conv_controller_if.master. Optional macro CONV_CTRL_PERF_EN adds
// stall_cycles/mac_cycles outputs.
module conv_controller
    import conv_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = 4,
    parameter int NUM_FILTERS = 4,
    parameter int PIPE_DEPTH  = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic finish_row,
    input  logic row_end,
    input  logic finish_filter,
    input  logic filter_end,
    output logic if_ld_head,
    output logic if_cnt_en,
    output logic if_clr,
    output logic if_stride,
    output logic f_ld_head,
    output logic f_cnt_en,
    output logic f_index_clr,
    output logic f_filter_cnt_en,
    output logic ram_ren,
    output logic sram_ren,
    output logic op_ld,
    output logic acc_ld,
    output logic acc_clr,
    conv_controller_if.master psum,
    output logic busy,
    output logic done
`ifdef CONV_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] mac_cycles
`endif
);

    // Filter sequencing is owned by the filter generator (filter_end), and
    // MAC exit keys on finish_filter alone, so these are informational.
    localparam int unused_num_filters = NUM_FILTERS;
    logic unused_finish_row;
    assign unused_finish_row = finish_row;

    state_e                state_q, state_d;
    logic                  drain_q, drain_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic                  psum_valid_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            drain_q <= 1'b0;
            waddr_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            waddr_q <= waddr_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        drain_d         = drain_q;
        waddr_d         = waddr_q;
        if_ld_head      = 1'b0;
        if_cnt_en       = 1'b0;
        if_clr          = 1'b0;
        if_stride       = 1'b0;
        f_ld_head       = 1'b0;
        f_cnt_en        = 1'b0;
        f_index_clr     = 1'b0;
        f_filter_cnt_en = 1'b0;
        ram_ren         = 1'b0;
        sram_ren        = 1'b0;
        acc_clr         = 1'b0;
        psum_valid_s    = 1'b0;
        busy            = 1'b1;
        done            = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                if_clr      = 1'b1;
                f_index_clr = 1'b1;
                acc_clr     = 1'b1;
                if_ld_head  = 1'b1;
                f_ld_head   = 1'b1;
                waddr_d     = '0;
                state_d     = S_MAC;
            end
            S_MAC: begin
                ram_ren   = 1'b1;
                sram_ren  = 1'b1;
                if_cnt_en = 1'b1;
                f_cnt_en  = 1'b1;
                // A window/filter size mismatch still ends on the filter.
                if (finish_filter) begin
                    drain_d = 1'b0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                psum_valid_s = 1'b1;
                if (psum.psum_ready) begin
                    waddr_d = waddr_q + 1'b1;
                    if (!filter_end) begin
                        state_d = S_NEXT_FILT;
                    end else if (!row_end) begin
                        state_d = S_NEXT_WIN;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_NEXT_FILT: begin
                f_filter_cnt_en = 1'b1;
                f_index_clr     = 1'b1;
                acc_clr         = 1'b1;
                if_ld_head      = 1'b1;
                state_d         = S_MAC;
            end
            S_NEXT_WIN: begin
                if_stride   = 1'b1;
                f_ld_head   = 1'b1;
                f_index_clr = 1'b1;
                acc_clr     = 1'b1;
                state_d     = S_MAC;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign psum.psum_valid = psum_valid_s;
    assign psum.psum_waddr = waddr_q;

    conv_ctrl_pipe #(
        .DEPTH(PIPE_DEPTH)
    ) u_pipe (
        .clk      (clk),
        .rst      (rst),
        .rd_vld_i (ram_ren),
        .op_ld_o  (op_ld),
        .acc_ld_o (acc_ld)
    );

`ifdef CONV_CTRL_PERF_EN
    logic [PERF_W-1:0] stall_q, stall_d;
    logic [PERF_W-1:0] mac_q, mac_d;

    always_comb begin
        stall_d = stall_q;
        mac_d   = mac_q;
        if (state_q == S_INIT) begin
            stall_d = '0;
            mac_d   = '0;
        end else begin
            if (state_q == S_WRITE && !psum.psum_ready && stall_q != '1) begin
                stall_d = stall_q + 1'b1;
            end
            if (state_q == S_MAC && mac_q != '1) begin
                mac_d = mac_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
            mac_q   <= '0;
        end else begin
            stall_q <= stall_d;
            mac_q   <= mac_d;
        end
    end

    assign stall_cycles = stall_q;
    assign mac_cycles   = mac_q;
`endif

endmodule

// File: tb/tb_conv_controller.sv
// tb_conv_controller: directed self-checking bench for conv_controller.
// Drives generator flags and the psum channel, checks strobes and counts.
`timescale 1ns/1ps
module tb_conv_controller;

    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic finish_row = 1'b0;
    logic row_end = 1'b0;
    logic finish_filter = 1'b0;
    logic filter_end = 1'b0;
    logic if_ld_head, if_cnt_en, if_clr, if_stride;
    logic f_ld_head, f_cnt_en, f_index_clr, f_filter_cnt_en;
    logic ram_ren, sram_ren, op_ld, acc_ld, acc_clr;
    logic busy, done;
`ifdef CONV_CTRL_PERF_EN
    logic [15:0] stall_cycles, mac_cycles;
`endif

    conv_controller_if #(.ADDR_WIDTH(AW)) psum_if ();

    conv_controller #(
        .ADDR_WIDTH(AW),
        .NUM_FILTERS(2),
        .PIPE_DEPTH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .finish_row(finish_row),
        .row_end(row_end),
        .finish_filter(finish_filter),
        .filter_end(filter_end),
        .if_ld_head(if_ld_head),
        .if_cnt_en(if_cnt_en),
        .if_clr(if_clr),
        .if_stride(if_stride),
        .f_ld_head(f_ld_head),
        .f_cnt_en(f_cnt_en),
        .f_index_clr(f_index_clr),
        .f_filter_cnt_en(f_filter_cnt_en),
        .ram_ren(ram_ren),
        .sram_ren(sram_ren),
        .op_ld(op_ld),
        .acc_ld(acc_ld),
        .acc_clr(acc_clr),
        .psum(psum_if.master),
        .busy(busy),
        .done(done)
`ifdef CONV_CTRL_PERF_EN
        ,
        .stall_cycles(stall_cycles),
        .mac_cycles(mac_cycles)
`endif
    );

    always #5 clk = ~clk;

    wire [15:0] outs = {if_ld_head, if_cnt_en, if_clr, if_stride,
                        f_ld_head, f_cnt_en, f_index_clr, f_filter_cnt_en,
                        ram_ren, sram_ren, op_ld, acc_ld, acc_clr,
                        psum_if.psum_valid, busy, done};

    int n_chk = 0;
    int n_err = 0;

    `define CHK(tag, obs, exp) \
        begin \
            n_chk++; \
            assert ((obs) === (exp)) else begin \
                n_err++; \
                $error("FAIL %s: got %0h expected %0h", tag, (obs), (exp)); \
            end \
        end

    // Event monitor, sampled on the falling edge.
    int cyc = 0;
    int rd_cnt = 0, op_cnt = 0, acc_cnt = 0, hs_cnt = 0;
    int stride_cnt = 0, fcnt_cnt = 0, done_cnt = 0;
    int ovl_cnt = 0, bad_clr = 0;
    int rd_rise = 0, op_rise = 0, acc_rise = 0, acc_last = 0;
    int val_rise = 0, init_cyc = 0;
    logic p_ren = 1'b0, p_op = 1'b0, p_acc = 1'b0, p_clr = 1'b0, p_val = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (ram_ren) rd_cnt <= rd_cnt + 1;
        if (ram_ren && !p_ren) rd_rise <= cyc;
        if (ram_ren && !p_ren && !p_clr) bad_clr <= bad_clr + 1;
        if (op_ld) op_cnt <= op_cnt + 1;
        if (op_ld && !p_op) op_rise <= cyc;
        if (acc_ld) begin
            acc_cnt  <= acc_cnt + 1;
            acc_last <= cyc;
        end
        if (acc_ld && !p_acc) acc_rise <= cyc;
        if (acc_ld && acc_clr) ovl_cnt <= ovl_cnt + 1;
        if (psum_if.psum_valid && psum_if.psum_ready) hs_cnt <= hs_cnt + 1;
        if (psum_if.psum_valid && !p_val) val_rise <= cyc;
        if (if_clr) init_cyc <= cyc;
        if (if_stride) stride_cnt <= stride_cnt + 1;
        if (f_filter_cnt_en) fcnt_cnt <= fcnt_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        p_ren <= ram_ren;
        p_op  <= op_ld;
        p_acc <= acc_ld;
        p_clr <= acc_clr;
        p_val <= psum_if.psum_valid;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start from IDLE; returns in the first MAC cycle.
    task automatic start_conv();
        start = 1'b1;
        step();
        start = 1'b0;
        `CHK("init_strobes",
             {if_clr, f_index_clr, acc_clr, if_ld_head, f_ld_head, busy},
             6'b111111)
        `CHK("init_no_read", ram_ren, 1'b0)
        step();
    endtask

    // One partial sum of k elements; entered in the first MAC cycle.
    task automatic run_psum(input int k, input bit fe, input bit re,
                            input int stall, input logic [AW-1:0] addr,
                            input bit poke_start);
        for (int i = 1; i <= k; i++) begin
            `CHK("mac_strobes", {ram_ren, sram_ren, if_cnt_en, f_cnt_en},
                 4'hF)
            if (i == k) begin
                finish_row    = 1'b1;
                finish_filter = 1'b1;
            end
            if (poke_start && i == 2) start = 1'b1;
            step();
            finish_row    = 1'b0;
            finish_filter = 1'b0;
            start         = 1'b0;
        end
        filter_end          = fe;
        row_end             = re;
        psum_if.psum_ready  = 1'b0;
        `CHK("drain_no_read", {ram_ren, psum_if.psum_valid}, 2'b00)
        step();
        `CHK("drain2_no_read", {ram_ren, psum_if.psum_valid}, 2'b00)
        step();
        `CHK("write_valid", {psum_if.psum_valid, psum_if.psum_waddr},
             {1'b1, addr})
        for (int s = 0; s < stall; s++) begin
            step();
            `CHK("stall_hold", {psum_if.psum_valid, psum_if.psum_waddr},
                 {1'b1, addr})
        end
        psum_if.psum_ready = 1'b1;
        step();
        psum_if.psum_ready = 1'b0;
        `CHK("after_hs_valid", psum_if.psum_valid, 1'b0)
        if (!fe) begin
            `CHK("next_filt",
                 {f_filter_cnt_en, f_index_clr, acc_clr, if_ld_head,
                  if_stride, f_ld_head}, 6'b111100)
            step();
        end else if (!re) begin
            `CHK("next_win",
                 {f_filter_cnt_en, f_index_clr, acc_clr, if_ld_head,
                  if_stride, f_ld_head}, 6'b011011)
            step();
        end else begin
            `CHK("done_pulse", {done, busy}, 2'b11)
            step();
            `CHK("idle_after_done", {done, busy}, 2'b00)
        end
    endtask

    int b_rd, b_op, b_acc, b_hs, b_str, b_fc, b_done;

    task automatic snap();
        b_rd   = rd_cnt;
        b_op   = op_cnt;
        b_acc  = acc_cnt;
        b_hs   = hs_cnt;
        b_str  = stride_cnt;
        b_fc   = fcnt_cnt;
        b_done = done_cnt;
    endtask

    initial begin
        psum_if.psum_ready = 1'b0;
        // Reset held with start high.
        rst   = 1'b0;
        start = 1'b1;
        step();
        step();
        `CHK("reset_outs", outs, 16'h0000)
        `CHK("reset_waddr", psum_if.psum_waddr, 4'h0)
`ifdef CONV_CTRL_PERF_EN
        `CHK("reset_perf", {stall_cycles, mac_cycles}, 32'h0)
`endif
        rst   = 1'b1;
        start = 1'b0;
        step();
        `CHK("idle_outs", outs, 16'h0000)

        // Single window, single filter, K=4.
        snap();
        start_conv();
        run_psum(4, 1'b1, 1'b1, 0, 4'd0, 1'b0);
        #4;
        `CHK("k4_reads", rd_cnt - b_rd, 4)
        `CHK("k4_opld", op_cnt - b_op, 4)
        `CHK("k4_accld", acc_cnt - b_acc, 4)
        `CHK("k4_psums", hs_cnt - b_hs, 1)
        `CHK("k4_done", done_cnt - b_done, 1)
        `CHK("op_lat", op_rise - rd_rise, 1)
        `CHK("acc_lat", acc_rise - rd_rise, 2)
        `CHK("acc_last", acc_last - rd_rise, 5)
        `CHK("valid_lat", val_rise - init_cyc, 7)
        step();

        // Backpressure: 5 stalled WRITE cycles.
        snap();
        start_conv();
        run_psum(4, 1'b1, 1'b1, 5, 4'd0, 1'b0);
        #4;
        `CHK("bp_psums", hs_cnt - b_hs, 1)
`ifdef CONV_CTRL_PERF_EN
        `CHK("bp_stall_cycles", stall_cycles, 16'd5)
        `CHK("bp_mac_cycles", mac_cycles, 16'd4)
`endif
        step();

        // Two filters x three windows, start poked while busy.
        snap();
        start_conv();
        for (int w = 0; w < 3; w++) begin
            for (int f = 0; f < 2; f++) begin
                run_psum(3, f == 1, w == 2, 0, 4'(w * 2 + f),
                         (w == 1 && f == 0));
            end
        end
        #4;
        `CHK("grid_psums", hs_cnt - b_hs, 6)
        `CHK("grid_stride", stride_cnt - b_str, 2)
        `CHK("grid_fcnt", fcnt_cnt - b_fc, 3)
        `CHK("grid_done", done_cnt - b_done, 1)
        `CHK("grid_reads", rd_cnt - b_rd, 18)
        `CHK("grid_end_waddr", psum_if.psum_waddr, 4'd6)
        step();

        // Reset after two MAC reads.
        start_conv();
        step();
        `CHK("pre_rst_busy", {ram_ren, op_ld, busy}, 3'b111)
        #2;
        rst = 1'b0;
        #1;
        `CHK("async_rst_outs", outs, 16'h0000)
        `CHK("async_rst_waddr", psum_if.psum_waddr, 4'h0)
        step();
        step();
        rst = 1'b1;
        step();
        `CHK("post_rst_idle", outs, 16'h0000)
        snap();
        start_conv();
        run_psum(4, 1'b1, 1'b1, 0, 4'd0, 1'b0);
        #4;
        `CHK("restart_psums", hs_cnt - b_hs, 1)
        `CHK("restart_reads", rd_cnt - b_rd, 4)

        // Global invariants across the whole run.
        `CHK("clr_ld_overlap", ovl_cnt, 0)
        `CHK("clr_before_mac", bad_clr, 0)

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
